// File: rtl/anycore_l15_reqgen_if.sv
// Request/response bundle between the AnyCore L1 caches, the L1.5 request
// generator and the L1.5. master = caches + L1.5 side, slave = request generator.
interface anycore_l15_reqgen_if #(
  parameter int PADDR_W = 40
);
  logic               anycore_ic2mem_reqvalid;
  logic [PADDR_W-1:0] anycore_ic2mem_reqaddr;
  logic               anycore_mem2ic_reqready;

  logic               anycore_dc2mem_ldvalid;
  logic [PADDR_W-1:0] anycore_dc2mem_ldaddr;
  logic               anycore_mem2dc_ldready;

  logic               anycore_dc2mem_stvalid;
  logic [PADDR_W-1:0] anycore_dc2mem_staddr;
  logic [63:0]        anycore_dc2mem_stdata;
  logic [2:0]         anycore_dc2mem_stsize;
  logic               anycore_mem2dc_stready;

  logic               resp_ifill;
  logic               resp_load;
  logic               resp_stack;

  logic               transducer_l15_val;
  logic [4:0]         transducer_l15_rqtype;
  logic [2:0]         transducer_l15_size;
  logic [PADDR_W-1:0] transducer_l15_address;
  logic [63:0]        transducer_l15_data;
  logic               transducer_l15_nc;
  logic               l15_transducer_header_ack;

  modport master (
    output anycore_ic2mem_reqvalid, anycore_ic2mem_reqaddr,
    output anycore_dc2mem_ldvalid, anycore_dc2mem_ldaddr,
    output anycore_dc2mem_stvalid, anycore_dc2mem_staddr,
    output anycore_dc2mem_stdata, anycore_dc2mem_stsize,
    output resp_ifill, resp_load, resp_stack,
    output l15_transducer_header_ack,
    input  anycore_mem2ic_reqready, anycore_mem2dc_ldready, anycore_mem2dc_stready,
    input  transducer_l15_val, transducer_l15_rqtype, transducer_l15_size,
    input  transducer_l15_address, transducer_l15_data, transducer_l15_nc
  );

  modport slave (
    input  anycore_ic2mem_reqvalid, anycore_ic2mem_reqaddr,
    input  anycore_dc2mem_ldvalid, anycore_dc2mem_ldaddr,
    input  anycore_dc2mem_stvalid, anycore_dc2mem_staddr,
    input  anycore_dc2mem_stdata, anycore_dc2mem_stsize,
    input  resp_ifill, resp_load, resp_stack,
    input  l15_transducer_header_ack,
    output anycore_mem2ic_reqready, anycore_mem2dc_ldready, anycore_mem2dc_stready,
    output transducer_l15_val, transducer_l15_rqtype, transducer_l15_size,
    output transducer_l15_address, transducer_l15_data, transducer_l15_nc
  );
endinterface

// File: rtl/anycore_l15_reqgen.sv
// Collects I-fill, load and store misses from the AnyCore L1s and issues them
// one at a time to the L1.5, at most one outstanding transaction per type.
//
// state | meaning
// IDLE  | no request presented; arbitrate among pending types
// REQ   | winner presented on transducer_l15_*, waiting for header_ack
module anycore_l15_reqgen #(
  parameter int PADDR_W = 40,
  parameter int IC_OFF  = 5,
  parameter int DC_OFF  = 5
) (
  input logic                clk,
  input logic                rst,
  anycore_l15_reqgen_if.slave bus
);

  typedef enum logic {S_IDLE, S_REQ} state_t;
  typedef enum logic [1:0] {T_IF, T_LD, T_ST} rtype_t;

  localparam logic [4:0] RQ_LD = 5'b00000;
  localparam logic [4:0] RQ_ST = 5'b00001;
  localparam logic [4:0] RQ_IF = 5'b10000;

  localparam logic [PADDR_W-1:0] IC_MASK = {PADDR_W{1'b1}} << IC_OFF;
  localparam logic [PADDR_W-1:0] DC_MASK = {PADDR_W{1'b1}} << DC_OFF;

  state_t             state;
  rtype_t             win;

  logic               if_pend, ld_pend, st_pend;
  logic               if_out, ld_out, st_out;
  logic [PADDR_W-1:0] if_addr, ld_addr, st_addr;
  logic [63:0]        st_data;
  logic [2:0]         st_size;

  logic               val_q;
  logic [4:0]         rqtype_q;
  logic [2:0]         size_q;
  logic [PADDR_W-1:0] address_q;
  logic [63:0]        data_q;

  logic               if_rdy, ld_rdy, st_rdy;
  logic               if_fire, ld_fire, st_fire;
  logic               hdr_ack;

  // L1 store data is little-endian; the L1.5 expects byte 0 in the top lane.
  function automatic logic [63:0] bswap64(input logic [63:0] d);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(7-i) +: 8];
    return r;
  endfunction

  assign if_rdy  = !if_pend && !if_out;
  assign ld_rdy  = !ld_pend && !ld_out;
  assign st_rdy  = !st_pend && !st_out;

  assign if_fire = bus.anycore_ic2mem_reqvalid && if_rdy;
  assign ld_fire = bus.anycore_dc2mem_ldvalid && ld_rdy;
  assign st_fire = bus.anycore_dc2mem_stvalid && st_rdy;

  assign hdr_ack = val_q && bus.l15_transducer_header_ack;

  assign bus.anycore_mem2ic_reqready = if_rdy;
  assign bus.anycore_mem2dc_ldready  = ld_rdy;
  assign bus.anycore_mem2dc_stready  = st_rdy;

  assign bus.transducer_l15_val     = val_q;
  assign bus.transducer_l15_rqtype  = rqtype_q;
  assign bus.transducer_l15_size    = size_q;
  assign bus.transducer_l15_address = address_q;
  assign bus.transducer_l15_data    = data_q;
  assign bus.transducer_l15_nc      = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      win       <= T_IF;
      if_pend   <= 1'b0;
      ld_pend   <= 1'b0;
      st_pend   <= 1'b0;
      if_out    <= 1'b0;
      ld_out    <= 1'b0;
      st_out    <= 1'b0;
      if_addr   <= '0;
      ld_addr   <= '0;
      st_addr   <= '0;
      st_data   <= '0;
      st_size   <= '0;
      val_q     <= 1'b0;
      rqtype_q  <= '0;
      size_q    <= '0;
      address_q <= '0;
      data_q    <= '0;
    end else begin
      if (if_fire) begin
        if_pend <= 1'b1;
        if_addr <= bus.anycore_ic2mem_reqaddr & IC_MASK;
      end
      if (ld_fire) begin
        ld_pend <= 1'b1;
        ld_addr <= bus.anycore_dc2mem_ldaddr & DC_MASK;
      end
      if (st_fire) begin
        st_pend <= 1'b1;
        st_addr <= bus.anycore_dc2mem_staddr;
        st_data <= bus.anycore_dc2mem_stdata;
        st_size <= bus.anycore_dc2mem_stsize;
      end

      // Responses retire outstanding bits; the header_ack below sets them
      // afterwards, so a same-edge ack of another type is not lost.
      if (bus.resp_ifill) if_out <= 1'b0;
      if (bus.resp_load)  ld_out <= 1'b0;
      if (bus.resp_stack) st_out <= 1'b0;

      case (state)
        S_IDLE: begin
          if (st_pend) begin
            state     <= S_REQ;
            win       <= T_ST;
            val_q     <= 1'b1;
            rqtype_q  <= RQ_ST;
            size_q    <= st_size;
            address_q <= st_addr;
            data_q    <= bswap64(st_data);
          end else if (ld_pend) begin
            state     <= S_REQ;
            win       <= T_LD;
            val_q     <= 1'b1;
            rqtype_q  <= RQ_LD;
            size_q    <= 3'b000;
            address_q <= ld_addr;
            data_q    <= '0;
          end else if (if_pend) begin
            state     <= S_REQ;
            win       <= T_IF;
            val_q     <= 1'b1;
            rqtype_q  <= RQ_IF;
            size_q    <= 3'b000;
            address_q <= if_addr;
            data_q    <= '0;
          end
        end
        S_REQ: begin
          if (hdr_ack) begin
            state     <= S_IDLE;
            val_q     <= 1'b0;
            rqtype_q  <= '0;
            size_q    <= '0;
            address_q <= '0;
            data_q    <= '0;
            case (win)
              T_ST: begin
                st_pend <= 1'b0;
                st_out  <= 1'b1;
              end
              T_LD: begin
                ld_pend <= 1'b0;
                ld_out  <= 1'b1;
              end
              T_IF: begin
                if_pend <= 1'b0;
                if_out  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_anycore_l15_reqgen.sv
// Directed, table-driven bench for anycore_l15_reqgen plus hand sequences for
// the ack/response collision and the mid-request reset.
module tb_anycore_l15_reqgen;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  anycore_l15_reqgen_if #(.PADDR_W(40)) bus ();

  anycore_l15_reqgen #(.PADDR_W(40), .IC_OFF(5), .DC_OFF(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ic_v;
    logic [39:0] ic_a;
    logic        ld_v;
    logic [39:0] ld_a;
    logic        st_v;
    logic [39:0] st_a;
    logic [63:0] st_d;
    logic [2:0]  st_s;
    logic        ack;
    logic        r_if;
    logic        r_ld;
    logic        r_st;
    logic        e_val;
    logic [4:0]  e_rq;
    logic [2:0]  e_sz;
    logic [39:0] e_addr;
    logic [63:0] e_data;
    logic [2:0]  e_rdy;   // {ic, ld, st}
  } vec_t;

  localparam int NV = 28;
  vec_t tv [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_val, input logic [4:0] e_rq,
                         input logic [2:0] e_sz, input logic [39:0] e_addr,
                         input logic [63:0] e_data, input logic [2:0] e_rdy);
    chk({tag, ".val"},    64'(bus.transducer_l15_val), 64'(e_val));
    chk({tag, ".rqtype"}, 64'(bus.transducer_l15_rqtype), 64'(e_rq));
    chk({tag, ".size"},   64'(bus.transducer_l15_size), 64'(e_sz));
    chk({tag, ".addr"},   64'(bus.transducer_l15_address), 64'(e_addr));
    chk({tag, ".data"},   bus.transducer_l15_data, e_data);
    chk({tag, ".nc"},     64'(bus.transducer_l15_nc), 64'd0);
    chk({tag, ".ready"},  64'({bus.anycore_mem2ic_reqready, bus.anycore_mem2dc_ldready,
                               bus.anycore_mem2dc_stready}), 64'(e_rdy));
  endtask

  task automatic idle_in();
    bus.anycore_ic2mem_reqvalid   = 1'b0;
    bus.anycore_ic2mem_reqaddr    = '0;
    bus.anycore_dc2mem_ldvalid    = 1'b0;
    bus.anycore_dc2mem_ldaddr     = '0;
    bus.anycore_dc2mem_stvalid    = 1'b0;
    bus.anycore_dc2mem_staddr     = '0;
    bus.anycore_dc2mem_stdata     = '0;
    bus.anycore_dc2mem_stsize     = '0;
    bus.resp_ifill                = 1'b0;
    bus.resp_load                 = 1'b0;
    bus.resp_stack                = 1'b0;
    bus.l15_transducer_header_ack = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;

    //          ic_v  ic_a               ld_v  ld_a               st_v  st_a       st_d                    st_s    ack   r_if  r_ld  r_st   e_val e_rq   e_sz    e_addr             e_data                  e_rdy
    tv[0]  = '{1'b1, 40'h00_8000_0047, 1'b0, 40'h0,             1'b0, 40'h0,  64'h0,                  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd0, 40'h0,             64'h0,                  3'b011};
    tv[1]  = '{1'b0, 40'h0,            1'b0, 40'h0,             1'b0, 40'h0,  64'h0,                  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h10, 3'd0, 40'h00_8000_0040, 64'h0,                  3'b011};
    tv[2]  = '{1'b0, 40'h0,            1'b0, 40'h0,             1'b0, 40'h0,  64'h0,                  3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd0, 40'h0,             64'h0,                  3'b011};
    tv[3]  = '{1'b0, 40'h0,            1'b0, 40'h0,             1'b0, 40'h0,  64'h0,                  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd0, 40'h0,             64'h0,                  3'b011};
    tv[4]  = '{1'b0, 40'h0,            1'b0, 40'h0,             1'b0, 40'h0,  64'h0,                  3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 3'd0, 40'h0,             64'h0,                  3'b111};
    tv[5]  = '{1'b0, 40'h0,            1'b0, 40'h0,             1'b1, 40'h10, 64'h0102030405060708,   3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd0, 40'h0,             64'h0,                  3'b110};
    tv[6]  = '{1'b0, 40'h0,            1'b0, 40'h0,             1'b0, 40'h0,  64'h0,                  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h01, 3'd3, 40'h10,            64'h0807060504030201,   3'b110};
    tv[7]  = '{1'b0, 40'h0,            1'b0, 40'h0,             1'b0, 40'h0,  64'h0,                  3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd0, 40'h0,             64'h0,                  3'b110};
    tv[8]  = '{1'b0, 40'h0,            1'b0, 40'h0,             1'b0, 40'h0,  64'h0,                  3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'h00, 3'd0, 40'h0,             64'h0,                  3'b110};
    tv[9]  = '{1'b0, 40'h0,            1'b0, 40'h0,             1'b0, 40'h0,  64'h0,                  3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'h00, 3'd0, 40'h0,             64'h0,                  3'b111};
    tv[10] = '{1'b1, 40'h123,          1'b1, 40'h3F,            1'b1, 40'h28, 64'h1122334455667788,   3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd0, 40'h0,             64'h0,                  3'b000};
    tv[11] = '{1'b0, 40'h0,            1'b0, 40'h0,             1'b0, 40'h0,  64'h0,                  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h01, 3'd2, 40'h28,            64'h8877665544332211,   3'b000};
    tv[12] = '{1'b0, 40'h0,            1'b0, 40'h0,             1'b0, 40'h0,  64'h0,                  3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd0, 40'h0,             64'h0,                  3'b000};
    tv[13] = '{1'b0, 40'h0,            1'b0, 40'h0,             1'b0, 40'h0,  64'h0,                  3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'h00, 3'd0, 40'h20,            64'h0,                  3'b000};
    tv[14] = '{1'b0, 40'h0,            1'b0, 40'h0,             1'b0, 40'h0,  64'h0,                  3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd0, 40'h0,             64'h0,                  3'b000};
    tv[15] = '{1'b0, 40'h0,            1'b0, 40'h0,             1'b0, 40'h0,  64'h0,                  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h10, 3'd0, 40'h120,           64'h0,                  3'b000};
    tv[16] = '{1'b0, 40'h0,            1'b0, 40'h0,             1'b0, 40'h0,  64'h0,                  3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd0, 40'h0,             64'h0,                  3'b000};
    tv[17] = '{1'b0, 40'h0,            1'b0, 40'h0,             1'b0, 40'h0,  64'h0,                  3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'h00, 3'd0, 40'h0,             64'h0,                  3'b111};
    tv[18] = '{1'b0, 40'h0,            1'b1, 40'h12_3456_789A,  1'b0, 40'h0,  64'h0,                  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd0, 40'h0,             64'h0,                  3'b101};
    tv[19] = '{1'b0, 40'h0,            1'b0, 40'h0,             1'b0, 40'h0,  64'h0,                  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h00, 3'd0, 40'h12_3456_7880, 64'h0,                  3'b101};
    tv[20] = '{1'b1, 40'h40,           1'b0, 40'h0,             1'b0, 40'h0,  64'h0,                  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h00, 3'd0, 40'h12_3456_7880, 64'h0,                  3'b001};
    tv[21] = '{1'b1, 40'hFFF,          1'b0, 40'h0,             1'b0, 40'h0,  64'h0,                  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h00, 3'd0, 40'h12_3456_7880, 64'h0,                  3'b001};
    tv[22] = '{1'b0, 40'h0,            1'b0, 40'h0,             1'b0, 40'h0,  64'h0,                  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h00, 3'd0, 40'h12_3456_7880, 64'h0,                  3'b001};
    tv[23] = '{1'b0, 40'h0,            1'b0, 40'h0,             1'b0, 40'h0,  64'h0,                  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h00, 3'd0, 40'h12_3456_7880, 64'h0,                  3'b001};
    tv[24] = '{1'b0, 40'h0,            1'b0, 40'h0,             1'b0, 40'h0,  64'h0,                  3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd0, 40'h0,             64'h0,                  3'b001};
    tv[25] = '{1'b0, 40'h0,            1'b0, 40'h0,             1'b0, 40'h0,  64'h0,                  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h10, 3'd0, 40'h40,            64'h0,                  3'b001};
    tv[26] = '{1'b0, 40'h0,            1'b0, 40'h0,             1'b0, 40'h0,  64'h0,                  3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'h00, 3'd0, 40'h0,             64'h0,                  3'b011};
    tv[27] = '{1'b0, 40'h0,            1'b0, 40'h0,             1'b0, 40'h0,  64'h0,                  3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 3'd0, 40'h0,             64'h0,                  3'b111};

    // Reset state
    idle_in();
    rst = 1'b1;
    #2;
    chk_out("rst_hold", 1'b0, 5'h00, 3'd0, 40'h0, 64'h0, 3'b111);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk_out("rst_rel", 1'b0, 5'h00, 3'd0, 40'h0, 64'h0, 3'b111);

    for (int i = 0; i < NV; i++) begin
      bus.anycore_ic2mem_reqvalid   = tv[i].ic_v;
      bus.anycore_ic2mem_reqaddr    = tv[i].ic_a;
      bus.anycore_dc2mem_ldvalid    = tv[i].ld_v;
      bus.anycore_dc2mem_ldaddr     = tv[i].ld_a;
      bus.anycore_dc2mem_stvalid    = tv[i].st_v;
      bus.anycore_dc2mem_staddr     = tv[i].st_a;
      bus.anycore_dc2mem_stdata     = tv[i].st_d;
      bus.anycore_dc2mem_stsize     = tv[i].st_s;
      bus.l15_transducer_header_ack = tv[i].ack;
      bus.resp_ifill                = tv[i].r_if;
      bus.resp_load                 = tv[i].r_ld;
      bus.resp_stack                = tv[i].r_st;
      step();
      chk_out($sformatf("v%0d", i), tv[i].e_val, tv[i].e_rq, tv[i].e_sz,
              tv[i].e_addr, tv[i].e_data, tv[i].e_rdy);
    end
    idle_in();

    // Same-edge header_ack for IF and resp_stack for the outstanding store
    bus.anycore_dc2mem_stvalid = 1'b1;
    bus.anycore_dc2mem_staddr  = 40'h8;
    bus.anycore_dc2mem_stdata  = 64'hA5;
    bus.anycore_dc2mem_stsize  = 3'd0;
    step();
    idle_in();
    step();
    chk_out("col_st", 1'b1, 5'h01, 3'd0, 40'h8, 64'hA500_0000_0000_0000, 3'b110);
    bus.l15_transducer_header_ack = 1'b1;
    step();
    idle_in();
    bus.anycore_ic2mem_reqvalid = 1'b1;
    bus.anycore_ic2mem_reqaddr  = 40'h01_0000_001F;
    step();
    idle_in();
    step();
    chk_out("col_if", 1'b1, 5'h10, 3'd0, 40'h01_0000_0000, 64'h0, 3'b010);
    bus.l15_transducer_header_ack = 1'b1;
    bus.resp_stack                = 1'b1;
    step();
    idle_in();
    chk_out("col_both", 1'b0, 5'h00, 3'd0, 40'h0, 64'h0, 3'b011);
    bus.resp_ifill = 1'b1;
    step();
    idle_in();
    chk_out("col_done", 1'b0, 5'h00, 3'd0, 40'h0, 64'h0, 3'b111);

    // Reset while IF is presented and LD is outstanding
    bus.anycore_dc2mem_ldvalid = 1'b1;
    bus.anycore_dc2mem_ldaddr  = 40'h55;
    step();
    idle_in();
    step();
    chk_out("mr_ld", 1'b1, 5'h00, 3'd0, 40'h40, 64'h0, 3'b101);
    bus.l15_transducer_header_ack = 1'b1;
    step();
    idle_in();
    bus.anycore_ic2mem_reqvalid = 1'b1;
    bus.anycore_ic2mem_reqaddr  = 40'h200;
    step();
    idle_in();
    step();
    chk_out("mr_if", 1'b1, 5'h10, 3'd0, 40'h200, 64'h0, 3'b001);
    #3 rst = 1'b1;
    #1;
    chk_out("mr_async", 1'b0, 5'h00, 3'd0, 40'h0, 64'h0, 3'b111);
    #1 rst = 1'b0;
    bus.resp_load = 1'b1;
    @(posedge clk);
    #1;
    idle_in();
    chk_out("mr_lateresp", 1'b0, 5'h00, 3'd0, 40'h0, 64'h0, 3'b111);
    step();
    chk_out("mr_quiet", 1'b0, 5'h00, 3'd0, 40'h0, 64'h0, 3'b111);
    bus.anycore_dc2mem_ldvalid = 1'b1;
    bus.anycore_dc2mem_ldaddr  = 40'h7;
    step();
    idle_in();
    chk_out("mr_cap", 1'b0, 5'h00, 3'd0, 40'h0, 64'h0, 3'b101);
    step();
    chk_out("mr_reissue", 1'b1, 5'h00, 3'd0, 40'h0, 64'h0, 3'b101);
    bus.l15_transducer_header_ack = 1'b1;
    step();
    idle_in();
    chk_out("mr_ack", 1'b0, 5'h00, 3'd0, 40'h0, 64'h0, 3'b101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/anycore_l15_reqgen.md
ANYCORE_L15_REQGEN -- requirements
Module: anycore_l15_reqgen

Interface
REQ-001 Parameter PADDR_W, 40, physical address width.
REQ-002 Parameter IC_OFF, 5, I-cache line offset bits zeroed in fill address.
REQ-003 Parameter DC_OFF, 5, D-cache line offset bits zeroed in load address.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 anycore_ic2mem_reqvalid / anycore_ic2mem_reqaddr  in  1 / PADDR_W  I-cache miss request and byte address.
REQ-007 anycore_mem2ic_reqready  out  1  I-cache request accepted when valid&ready.
REQ-008 anycore_dc2mem_ldvalid / anycore_dc2mem_ldaddr  in  1 / PADDR_W  D-cache load miss request.
REQ-009 anycore_mem2dc_ldready  out  1  load request accepted when valid&ready.
REQ-010 anycore_dc2mem_stvalid / stаddr / stdata / stsize  in  1 / PADDR_W / 64 / 3  store request, little-endian data, size code.
REQ-011 anycore_mem2dc_stready  out  1  store request accepted when valid&ready.
REQ-012 resp_ifill / resp_load / resp_stack  in  1 each  single-cycle completion pulses from the L1.5 response encoder.
REQ-013 transducer_l15_val  out  1  request valid to L1.5.
REQ-014 transducer_l15_rqtype / size / address / data / nc  out  5 / 3 / PADDR_W / 64 / 1  request fields.
REQ-015 l15_transducer_header_ack  in  1  L1.5 accepts request on cycle where val&header_ack.

Function
REQ-016 Per type (IF, LD, ST) one pending register and one outstanding bit; ready = !pending & !outstanding.
REQ-017 Capture on valid&ready: pending set next edge; IF address stored with low IC_OFF bits zero, LD with low DC_OFF bits zero, ST address/data/size unmodified.
REQ-018 FSM states IDLE, REQ; IDLE->REQ when any pending bit set, latching winner; REQ->IDLE on val&header_ack.
REQ-019 Arbitration fixed priority ST > LD > IF, evaluated only in IDLE; winner held stable through REQ.
REQ-020 transducer_l15_val = 1 exactly in REQ; all fields constant while val high and header_ack low.
REQ-021 rqtype: LD 5'b00000, ST 5'b00001, IF 5'b10000.
REQ-022 size: ST passes stsize; LD and IF drive 3'b000.
REQ-023 data: ST drives stdata byte-swapped (byte 0 to bits 63:56 ... byte 7 to bits 7:0); LD/IF drive 0.
REQ-024 nc = 0 for all types.
REQ-025 On val&header_ack edge: winner pending cleared, winner outstanding set, FSM to IDLE; next REQ earliest one cycle later.
REQ-026 Minimum latency: capture edge N, val high cycle N+1 (IDLE at N, pending visible).
REQ-027 resp_* pulse clears matching outstanding at next edge; ready rises the cycle after.
REQ-028 resp_* with matching outstanding clear is ignored (no state change).
REQ-029 header_ack while val low is ignored.
REQ-030 Same-cycle header_ack and response for different types both take effect.
REQ-031 Up to three transactions (one per type) outstanding concurrently; no second request of a type until its response.

Reset
REQ-032 rst asserted: FSM IDLE, all pending/outstanding clear, val 0, all request fields 0, all ready outputs 1 after release.
REQ-033 rst mid-REQ or with outstanding: state discarded immediately (asynchronous); responses arriving after release ignored per REQ-028.

Verification
REQ-034 IF req addr 0x00_8000_0047 -> val next cycle, rqtype 5'b10000, address 0x00_8000_0040, size 0; reqready low until resp_ifill+1.
REQ-035 ST addr 0x10, data 0x0102030405060708, size 3'b011 -> data 0x0807060504030201, rqtype 5'b00001, size 3'b011.
REQ-036 IF, LD, ST valid same cycle, header_ack immediately each time -> issue order ST, LD, IF, one idle cycle between vals.
REQ-037 header_ack withheld 5 cycles -> val and all fields stable 5+ cycles; issue on ack cycle only.
REQ-038 rst pulsed while val high with LD outstanding -> val 0 immediately, all ready 1; later resp_load produces no change.
REQ-039 resp_load with no LD outstanding -> no output change; simultaneous header_ack(IF) and resp_stack -> IF outstanding set, ST outstanding cleared same edge.
